// File: rtl/toggle_cover_detect.sv
// ---------------------------------------------------------------------------
// toggle_cover_detect
//
// Watches a WIDTH-bit design signal and records, per bit, whether both a
// rising and a falling transition have been observed since the block was
// armed. The first time a bit completes a full toggle it produces a
// one-cycle pulse on valid[i], which feeds the downstream toggle-coverage
// reporter directly. A sticky coverage bitmap, its popcount and an
// all-covered flag are also kept for cover properties.
//
// Ports:
//   clock         - sole clock, all state updates on posedge
//   reset         - asynchronous active-low reset (0 = in reset)
//   enable        - 1 = evaluate transitions, 0 = only track the signal
//   clear         - synchronous restart of all coverage state, beats enable
//   sig           - monitored design signal
//   valid         - one-cycle pulse per bit on its first full toggle
//   covered       - sticky bitmap of fully toggled bits
//   covered_count - popcount of covered
//   all_covered   - 1 when every bit is covered
// ---------------------------------------------------------------------------
module toggle_cover_detect #(
  parameter  int WIDTH = 11,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] valid,
  output logic [WIDTH-1:0] covered,
  output logic [CNT_W-1:0] covered_count,
  output logic             all_covered
);

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_ROSE = 2'd1,
    ST_FELL = 2'd2,
    ST_DONE = 2'd3
  } bitState_e;

  bitState_e        state_q [WIDTH];
  bitState_e        state_d [WIDTH];
  logic [WIDTH-1:0] prev_q;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] covered_q, covered_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             all_q, all_d;
  logic [WIDTH-1:0] rise, fall;
  logic             evalEdges;

  assign rise = ~prev_q & sig;
  assign fall = prev_q & ~sig;

  // The arming cycle only captures a baseline, so edges are evaluated only
  // once armed was already set before this posedge.
  assign evalEdges = armed_q & enable & ~clear;

  // Next-state for the arming flag, the per-bit toggle FSMs and the derived
  // coverage outputs. Count and all-covered come from the next-state bitmap
  // so they move on the same edge as covered itself.
  always_comb begin
    armed_d = armed_q;
    if (clear) begin
      armed_d = 1'b0;
    end else if (enable) begin
      armed_d = 1'b1;
    end

    valid_d   = '0;
    covered_d = '0;
    count_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      if (clear) begin
        state_d[i] = ST_NONE;
      end else if (evalEdges) begin
        case (state_q[i])
          ST_NONE: begin
            if (rise[i])      state_d[i] = ST_ROSE;
            else if (fall[i]) state_d[i] = ST_FELL;
          end
          ST_ROSE: if (fall[i]) state_d[i] = ST_DONE;
          ST_FELL: if (rise[i]) state_d[i] = ST_DONE;
          default: state_d[i] = ST_DONE;
        endcase
      end
      covered_d[i] = (state_d[i] == ST_DONE);
      // DONE is absorbing, so a pulse can only happen on the entering edge.
      valid_d[i]   = (state_d[i] == ST_DONE) && (state_q[i] != ST_DONE);
      count_d      = count_d + CNT_W'(covered_d[i]);
    end
    all_d = &covered_d;
  end

  // State registers. prev tracks sig on every non-reset edge, so transitions
  // seen while disabled are consumed rather than deferred.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_NONE;
      end
      prev_q    <= '0;
      armed_q   <= 1'b0;
      valid_q   <= '0;
      covered_q <= '0;
      count_q   <= '0;
      all_q     <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
      end
      prev_q    <= sig;
      armed_q   <= armed_d;
      valid_q   <= valid_d;
      covered_q <= covered_d;
      count_q   <= count_d;
      all_q     <= all_d;
    end
  end

  assign valid         = valid_q;
  assign covered       = covered_q;
  assign covered_count = count_q;
  assign all_covered   = all_q;

endmodule

// File: tb/tb_toggle_cover_detect.sv
// ---------------------------------------------------------------------------
// tb_toggle_cover_detect
//
// Directed scenarios with hand-computed expectations, followed by a long
// randomized run. A behavioural model keeps per-bit "seen a rise" and
// "seen a fall" flags and derives coverage from them; every cycle the DUT
// outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_toggle_cover_detect;

  localparam int W  = 11;
  localparam int CW = $clog2(W + 1);

  logic          clock;
  logic          reset;
  logic          enable;
  logic          clear;
  logic [W-1:0]  sig;
  logic [W-1:0]  valid;
  logic [W-1:0]  covered;
  logic [CW-1:0] covered_count;
  logic          all_covered;

  int errors = 0;
  int checks = 0;

  bit           mArmed = 1'b0;
  bit [W-1:0]   mPrev  = '0;
  bit [W-1:0]   mRise  = '0;
  bit [W-1:0]   mFall  = '0;
  bit [W-1:0]   mCov   = '0;
  bit [W-1:0]   mValid = '0;

  toggle_cover_detect #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .clear         (clear),
    .sig           (sig),
    .valid         (valid),
    .covered       (covered),
    .covered_count (covered_count),
    .all_covered   (all_covered)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural reference: a bit is covered once both a rise and a fall have
  // been seen while armed and enabled; valid marks bits newly covered.
  always @(posedge clock or negedge reset) begin
    bit [W-1:0] r, f, newly;
    if (!reset) begin
      mArmed = 1'b0;
      mPrev  = '0;
      mRise  = '0;
      mFall  = '0;
      mCov   = '0;
      mValid = '0;
    end else begin
      r = ~mPrev & sig;
      f = mPrev & ~sig;
      mValid = '0;
      if (clear) begin
        mArmed = 1'b0;
        mRise  = '0;
        mFall  = '0;
        mCov   = '0;
      end else if (enable && !mArmed) begin
        mArmed = 1'b1;
      end else if (enable) begin
        mRise  = mRise | r;
        mFall  = mFall | f;
        newly  = mRise & mFall & ~mCov;
        mValid = newly;
        mCov   = mCov | newly;
      end
      mPrev = sig;
    end
  end

  // Literal expectation check.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare all DUT outputs against the behavioural model.
  task automatic compareModel();
    checkOutput("model_valid",   32'(valid),         32'(mValid));
    checkOutput("model_covered", 32'(covered),       32'(mCov));
    checkOutput("model_count",   32'(covered_count), 32'($countones(mCov)));
    checkOutput("model_all",     32'(all_covered),   32'(&mCov));
  endtask

  task automatic checkAll(input string name, input logic [W-1:0] expValid,
                          input logic [W-1:0] expCov, input int expCount,
                          input logic expAll);
    checkOutput({name, "_valid"},   32'(valid),         32'(expValid));
    checkOutput({name, "_covered"}, 32'(covered),       32'(expCov));
    checkOutput({name, "_count"},   32'(covered_count), 32'(expCount));
    checkOutput({name, "_all"},     32'(all_covered),   32'(expAll));
  endtask

  // Drive one cycle of inputs from a negedge, compare against the model just
  // after the posedge, and return at the following negedge.
  task automatic applyStimulus(input logic en, input logic clr, input logic [W-1:0] s);
    enable = en;
    clear  = clr;
    sig    = s;
    @(posedge clock);
    #1;
    compareModel();
    @(negedge clock);
  endtask

  initial begin
    logic [W-1:0] s;
    logic [W-1:0] mask;
    reset  = 1'b0;
    enable = 1'b0;
    clear  = 1'b0;
    sig    = 11'h7FF;
    @(negedge clock);

    // Reset held with sig all ones.
    repeat (3) applyStimulus(1'b1, 1'b0, 11'h7FF);
    checkAll("in_reset", 11'h000, 11'h000, 0, 1'b0);
    reset = 1'b1;

    // Baseline only: arming then a static signal.
    repeat (3) begin
      applyStimulus(1'b1, 1'b0, 11'h7FF);
      checkAll("baseline", 11'h000, 11'h000, 0, 1'b0);
    end

    // Single-bit full toggle, then repeated toggles must not pulse again.
    applyStimulus(1'b1, 1'b1, 11'h000);
    applyStimulus(1'b1, 1'b0, 11'h000);
    applyStimulus(1'b1, 1'b0, 11'h001);
    checkAll("bit0_rise", 11'h000, 11'h000, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 11'h000);
    checkAll("bit0_done", 11'h001, 11'h001, 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 11'h000);
    checkAll("bit0_after", 11'h000, 11'h001, 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 11'h001);
    applyStimulus(1'b1, 1'b0, 11'h000);
    checkAll("bit0_repeat", 11'h000, 11'h001, 1, 1'b0);

    // All bits complete on the same edge.
    applyStimulus(1'b1, 1'b1, 11'h000);
    applyStimulus(1'b1, 1'b0, 11'h000);
    applyStimulus(1'b1, 1'b0, 11'h7FF);
    applyStimulus(1'b1, 1'b0, 11'h000);
    checkAll("all_done", 11'h7FF, 11'h7FF, 11, 1'b1);
    applyStimulus(1'b1, 1'b0, 11'h7FF);
    checkAll("all_hold", 11'h000, 11'h7FF, 11, 1'b1);

    // Fall while disabled is lost; a later fall completes the toggle.
    applyStimulus(1'b1, 1'b1, 11'h000);
    applyStimulus(1'b1, 1'b0, 11'h000);
    applyStimulus(1'b1, 1'b0, 11'h008);
    applyStimulus(1'b0, 1'b0, 11'h000);
    applyStimulus(1'b1, 1'b0, 11'h000);
    checkAll("bit3_lost", 11'h000, 11'h000, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 11'h008);
    applyStimulus(1'b1, 1'b0, 11'h000);
    checkAll("bit3_done", 11'h008, 11'h008, 1, 1'b0);

    // Clear wins over a completing edge on bit4, next edge only re-arms.
    applyStimulus(1'b1, 1'b1, 11'h000);
    applyStimulus(1'b1, 1'b0, 11'h000);
    applyStimulus(1'b1, 1'b0, 11'h00F);
    applyStimulus(1'b1, 1'b0, 11'h000);
    checkAll("low4_done", 11'h00F, 11'h00F, 4, 1'b0);
    applyStimulus(1'b1, 1'b0, 11'h010);
    applyStimulus(1'b1, 1'b1, 11'h000);
    checkAll("clear_edge", 11'h000, 11'h000, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 11'h000);
    checkAll("rearm", 11'h000, 11'h000, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 11'h010);
    applyStimulus(1'b1, 1'b0, 11'h000);
    checkAll("bit4_done", 11'h010, 11'h010, 1, 1'b0);

    // Asynchronous reset between clock edges.
    applyStimulus(1'b1, 1'b1, 11'h000);
    applyStimulus(1'b1, 1'b0, 11'h000);
    applyStimulus(1'b1, 1'b0, 11'h01F);
    applyStimulus(1'b1, 1'b0, 11'h000);
    checkAll("five_done", 11'h01F, 11'h01F, 5, 1'b0);
    applyStimulus(1'b1, 1'b0, 11'h000);
    #2;
    reset = 1'b0;
    #1;
    checkAll("async_reset", 11'h000, 11'h000, 0, 1'b0);
    compareModel();
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 11'h3A5);
    reset = 1'b1;

    // Randomized run: sparse bit flips, mostly enabled, occasional clear.
    s = 11'(($urandom));
    for (int n = 0; n < 800; n++) begin
      mask = 11'($urandom & $urandom & $urandom);
      s = s ^ mask;
      applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 79) == 0), s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toggle_cover_detect.md
Name: toggle_cover_detect

Overview:
- Upstream stage of the per-signal toggle-coverage reporter (the GEN_wN_toggle family).
- Watches a WIDTH-bit design signal and tracks, per bit, whether both a 0->1 and a 1->0 transition have been seen since the block was armed.
- Emits a one-cycle `valid[i]` pulse the first time bit i completes a full toggle. That pulse vector drives the reporter's `valid` input directly.
- Also keeps a sticky coverage bitmap and a covered-bit count for formal/BMC cover properties.

Parameters:
- WIDTH, 11, number of monitored bits; equals the downstream reporter width.
- CNT_W, $clog2(WIDTH+1), width of `covered_count`; derived, do not override.

Ports:
- clock, input, 1, sole clock; all state updates on posedge.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- enable, input, 1, 1 = evaluate transitions; 0 = track the signal only.
- clear, input, 1, synchronous restart of coverage state; overrides enable.
- sig, input, WIDTH, monitored design signal.
- valid, output, WIDTH, one-cycle pulse per bit on first full toggle; feeds the reporter.
- covered, output, WIDTH, sticky bitmap of fully toggled bits.
- covered_count, output, CNT_W, popcount of `covered`.
- all_covered, output, 1, registered; 1 when `covered` is all ones.

Behaviour:
- Reset (reset=0, async): all outputs 0, `armed`=0, `prev`=0, every per-bit FSM = NONE. Reset mid-operation discards all progress.
- Per-bit FSM states (2 bits per bit):
  - NONE -> ROSE on rise; NONE -> FELL on fall.
  - ROSE -> DONE on fall; FELL -> DONE on rise.
  - DONE is absorbing until clear/reset.
  - Edge of the same kind as the state already holds: no change (e.g. ROSE + rise stays ROSE).
- Edge detection at a posedge: rise[i] = !prev[i] & sig[i]; fall[i] = prev[i] & !sig[i]. Edges count only when armed=1 and enable=1 and clear=0.
- `prev` loads `sig` at every posedge not in reset, regardless of enable/clear. Transitions that occur while enable=0 are lost, not deferred.
- Arming: the first posedge with enable=1 and armed=0 loads `prev`, sets armed=1 and evaluates no edges, so the first sample is the baseline. armed stays 1 through enable=0 and is cleared only by reset/clear.
- valid[i]: registered; 1 for exactly one cycle after the posedge at which bit i enters DONE; 0 otherwise. It can never pulse twice for the same bit without an intervening clear/reset.
- covered[i] = (state[i]==DONE). It is set at the same posedge valid[i] rises.
- covered_count and all_covered are computed from next-state `covered`, so they update at the same posedge as `covered` (no extra latency).
- Multiple bits completing at the same posedge pulse together; the count increases by the number of those bits.
- clear=1 at a posedge:
  - all FSMs -> NONE; valid, covered, covered_count, all_covered -> 0; armed -> 0; prev <= sig.
  - Edges sampled at that posedge are ignored.
  - The next posedge with enable=1 re-arms, following the arming rule above.
- Bits in DONE ignore further edges. The popcount never exceeds WIDTH and never wraps.
- Formal-friendly: no X sources. All state is reset or loaded on every cycle.

Test Plan:
- Reset held 0 with sig=0x7FF, then released; enable=1 and sig held for 3 cycles -> valid=0, covered=0, covered_count=0 throughout (baseline only).
- Armed at sig=0x000; sig bit0 1 then 0 on consecutive posedges -> at the second posedge valid=0x001 for one cycle, then covered=0x001, covered_count=1. Repeating the pulse -> valid stays 0.
- Armed at sig=0x000; sig=0x7FF then 0x000 -> valid=0x7FF for one cycle, covered_count=11, all_covered=1.
- Armed; bit3 rises while enable=1, then falls while enable=0, then enable=1 -> covered[3]=0 (fall lost). A later fall/rise pair completes it -> valid=0x008.
- With covered=0x00F, assert clear together with a completing edge on bit4 -> at that posedge all outputs 0 and valid[4]=0; the next posedge only re-arms.
- Mid-run with covered_count=5, pulse reset=0 asynchronously between clock edges -> all outputs 0 immediately, before the next posedge.
